pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Frame-synchronous scheduler that owns the `pattern_enable` and `step_size` inputs of every pattern generator (spiral, etc.) in the VGA pipeline.
- Shows one generator at a time for a programmable number of frames, inserts a short black gap, then advances to the next generator with wrap-around.
- Supports a manual-advance request and a hold input.
- Sits between the frame timing / button logic and the generator bank; its `blank` output gates the final RGB mux.

## Interface
Parameters:
- `NUM_PATTERNS`, 4: number of generators, legal 2..8.
- `DWELL_FRAMES`, 600: frames each pattern is shown, ≥1.
- `BLANK_FRAMES`, 2: black frames between patterns, ≥1.
- `RAMP_FRAMES`, 60: frames per step_size increment (ramp build only), ≥1.
- `MAX_STEP`, 7: ramp ceiling, 1..7.
- `DEFAULT_STEP`, 2: fixed step_size when ramp compiled out, 0..7.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `next_frame` in 1: one-cycle pulse per frame.
- `advance` in 1: one-cycle debounced manual-advance request.
- `hold` in 1: level; freezes dwell and ramp counting.
- `pattern_enable` out NUM_PATTERNS: one-hot generator enable, all-zero in BLANK.
- `pattern_sel` out $clog2(NUM_PATTERNS): index of current/next pattern for the RGB mux.
- `step_size` out 3: speed to generators.
- `blank` out 1: high in BLANK; RGB mux forces black.

## Operation
- FSM, two states:
  - SHOW: `pattern_enable = 1 << pattern_sel`, `blank = 0`.
  - BLANK: `pattern_enable = 0`, `blank = 1`.
- Reset values: state SHOW, `pattern_sel = 0`, `pattern_enable = 1`, `blank = 0`, counters 0.
  - `step_size = 1` with ramp, `DEFAULT_STEP` without.
- All state changes occur only on `next_frame` cycles (no mid-frame tearing).
- Dwell counter, SHOW:
  - Increments on each `next_frame` unless `hold`.
  - On a `next_frame` where the counter equals DWELL_FRAMES-1, or where `advance_pending` is set: go to BLANK, clear counter and pending.
  - Net effect: each pattern is visible for exactly DWELL_FRAMES frames absent advance/hold.
- BLANK:
  - Counts every `next_frame`; `hold` is ignored.
  - On the `next_frame` where the counter equals BLANK_FRAMES-1:
    - `pattern_sel` ← `pattern_sel + 1`, wrapping from NUM_PATTERNS-1 to 0.
    - Clear counter, enter SHOW.
- `advance_pending`:
  - Set by `advance` in SHOW; cleared on the SHOW→BLANK transition.
  - `advance` in BLANK is dropped.
  - `advance` coincident with `next_frame` in SHOW takes effect on that same frame.
- `hold` only inhibits the SHOW dwell and ramp counters; manual advance still works while holding.
- Widths:
  - Counters are $clog2(max(DWELL_FRAMES, BLANK_FRAMES, RAMP_FRAMES)+1) bits.
  - All compares are unsigned.
- Reset asserted mid-operation returns every register to its reset value immediately (async).

## Timing
- All outputs are registered.
- Changes appear the cycle after the qualifying `next_frame` (1-cycle latency).
- `pattern_sel` and `pattern_enable` change in the same cycle.
- `blank` rises in the same cycle `pattern_enable` goes to zero.
- `step_size` changes in the same cycle as the SHOW entry or ramp tick that causes it.
- The generator sees its new `pattern_enable` before the next `next_frame`, so its first enabled frame update is the following frame.

## Configuration
Macro `PATTERN_SEQ_RAMP_EN`.

When defined:
- Ramp counter counts `next_frame` in SHOW when `hold` is low.
- Every RAMP_FRAMES frames, `step_size` increments, saturating at MAX_STEP.
- Entering SHOW resets `step_size` to 1 and the ramp counter to 0.
- `step_size` holds its value in BLANK.

When undefined:
- No ramp counter is built.
- `step_size` is constant DEFAULT_STEP from reset onward.

## Structure
- `pattern_pkg` holds:
  - the `seq_state_t` enum (SHOW, BLANK);
  - `STEP_W = 3`;
  - a `pattern index width` helper function shared with the RGB mux.
- One sub-module, `seq_frame_timer`, used for the dwell/blank counter (and the ramp counter):
  - `next_frame`-qualified counter with enable, sync clear and terminal-count compare.
- FSM and one-hot decode live in the top.

## Test plan
Bench parameters: NUM_PATTERNS=3, DWELL_FRAMES=4, BLANK_FRAMES=2, RAMP_FRAMES=2, MAX_STEP=3, ramp enabled unless noted.
1. Free run, 12 `next_frame` pulses from reset → enables 001×4, 000×2, 010×4, 000×2; `blank` high exactly during the 000 frames.
2. Wrap: continue to pattern 2, then its blank → `pattern_sel` returns to 0, `pattern_enable = 001`.
3. `advance` pulsed during frame 1 of SHOW → BLANK after that frame's `next_frame`. `advance` coincident with `next_frame` → BLANK on that pulse. `advance` in BLANK → gap still exactly 2 frames, next pattern shown full 4 frames.
4. `hold` high for 10 frames in SHOW → `pattern_sel` and `step_size` unchanged. `advance` while holding → still transitions.
5. Ramp: `step_size` reads 1, 2, 3, 3 at SHOW frames 0, 2, 4, 6 (DWELL raised to 8) and resets to 1 on the next SHOW. Ramp compiled out → constant 2.
6. Assert `rst` in BLANK mid-frame → next cycle: `pattern_sel = 0`, `pattern_enable = 001`, `blank = 0`, `step_size = 1`.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// Shared types and helpers for the pattern sequencer and the RGB mux that consumes pattern_sel.
// Latency: none (package only).
// Backpressure: none (package only).
package pattern_pkg;

    localparam int STEP_W = 3;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } seq_state_t;

    // Width of a pattern index; never below one bit so a single-pattern bank still has a select.
    function automatic int pat_idx_w(input int num_patterns);
        return (num_patterns > 1) ? $clog2(num_patterns) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Bundle between frame timing / button logic, the sequencer and the generator bank.
// Latency: none (wires only).
// Backpressure: none; all signals are frame-rate pulses or levels.
// Ports: next_frame/advance/hold into the sequencer; pattern_enable, pattern_sel,
//        step_size and blank out of it. master = sequencer side, slave = environment side.
interface pattern_sequencer_if #(
    parameter int NUM_PATTERNS = 4
);
    import pattern_pkg::*;

    localparam int SEL_W = pat_idx_w(NUM_PATTERNS);

    logic                    next_frame;
    logic                    advance;
    logic                    hold;
    logic [NUM_PATTERNS-1:0] pattern_enable;
    logic [SEL_W-1:0]        pattern_sel;
    logic [STEP_W-1:0]       step_size;
    logic                    blank;

    modport master (
        input  next_frame, advance, hold,
        output pattern_enable, pattern_sel, step_size, blank
    );

    modport slave (
        output next_frame, advance, hold,
        input  pattern_enable, pattern_sel, step_size, blank
    );

endinterface

// File: rtl/pattern_sequencer_frame_timer.sv
// Frame counter: advances on next_frame when enabled, sync clear wins, flags terminal count.
// Latency: count updates one cycle after the qualifying next_frame; at_term is combinational on count.
// Backpressure: none; en simply freezes the count.
// Ports: clk, rst (async high), next_frame, en, clr, terminal -> count, at_term.
module seq_frame_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_frame,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (next_frame && en) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == terminal);

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous scheduler: shows one generator for DWELL_FRAMES, blanks BLANK_FRAMES, advances with wrap.
// Latency: every output is registered and moves one cycle after the qualifying next_frame.
// Backpressure: none; advance is latched until the next frame boundary, hold freezes SHOW counting.
// Ports: clk, rst (async high), bus (pattern_sequencer_if.master).
// Build option: define PATTERN_SEQ_RAMP_EN to ramp step_size during SHOW; otherwise step_size = DEFAULT_STEP.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 600,
    parameter int BLANK_FRAMES = 2,
    parameter int RAMP_FRAMES  = 60,
    parameter int MAX_STEP     = 7,
    parameter int DEFAULT_STEP = 2
) (
    input  logic                clk,
    input  logic                rst,
    pattern_sequencer_if.master bus
);

    localparam int SEL_W = pat_idx_w(NUM_PATTERNS);
    localparam int CNT_W = $clog2(max3(DWELL_FRAMES, BLANK_FRAMES, RAMP_FRAMES) + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);

    // Out-of-range parameters leave this marker block in the elaborated hierarchy.
    if (NUM_PATTERNS < 2 || NUM_PATTERNS > 8 || DWELL_FRAMES < 1 || BLANK_FRAMES < 1 ||
        RAMP_FRAMES < 1 || MAX_STEP < 1 || MAX_STEP > 7 || DEFAULT_STEP < 0 || DEFAULT_STEP > 7)
    begin : g_illegal_parameters
    end

    seq_state_t              state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    pend_q, pend_d;
    logic [NUM_PATTERNS-1:0] enable_q;
    logic                    blank_q;

    logic                    cnt_en, cnt_clr, cnt_tc;
    logic [CNT_W-1:0]        cnt_terminal;
    logic [CNT_W-1:0]        cnt_value;

    // One counter serves both phases: dwell in SHOW, gap length in BLANK.
    assign cnt_terminal = (state_q == SHOW) ? DWELL_LAST : BLANK_LAST;

    seq_frame_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .next_frame (bus.next_frame),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .terminal   (cnt_terminal),
        .count      (cnt_value),
        .at_term    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            SHOW: begin
                cnt_en = !bus.hold;
                // A held dwell counter is frozen, so its terminal value must not expire the pattern;
                // advance (pending or arriving with this frame pulse) still does.
                if (bus.next_frame && (pend_q || bus.advance || (cnt_tc && !bus.hold))) begin
                    state_d = BLANK;
                    cnt_clr = 1'b1;
                    pend_d  = 1'b0;
                end else if (bus.advance) begin
                    pend_d = 1'b1;
                end
            end
            BLANK: begin
                cnt_en = 1'b1;
                if (bus.next_frame && cnt_tc) begin
                    state_d = SHOW;
                    cnt_clr = 1'b1;
                    sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end
            end
            default: begin
                state_d = SHOW;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SHOW;
            sel_q    <= '0;
            pend_q   <= 1'b0;
            enable_q <= NUM_PATTERNS'(1);
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            // Decode from next-state so enable, select and blank all move on the same cycle.
            enable_q <= (state_d == SHOW) ? (NUM_PATTERNS'(1) << sel_d) : '0;
            blank_q  <= (state_d == BLANK);
        end
    end

    assign bus.pattern_enable = enable_q;
    assign bus.pattern_sel    = sel_q;
    assign bus.blank          = blank_q;

`ifdef PATTERN_SEQ_RAMP_EN
    localparam logic [CNT_W-1:0]  RAMP_LAST = CNT_W'(RAMP_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEP);

    logic              enter_show;
    logic              ramp_en, ramp_tc, ramp_tick;
    logic [CNT_W-1:0]  ramp_count;
    logic [STEP_W-1:0] step_q;

    assign enter_show = (state_q == BLANK) && (state_d == SHOW);
    assign ramp_en    = (state_q == SHOW) && !bus.hold;
    // No tick on the frame that leaves SHOW: step_size must stay put through BLANK.
    assign ramp_tick  = bus.next_frame && ramp_en && ramp_tc && (state_d == SHOW);

    seq_frame_timer #(
        .CNT_W (CNT_W)
    ) u_ramp_timer (
        .clk        (clk),
        .rst        (rst),
        .next_frame (bus.next_frame),
        .en         (ramp_en),
        .clr        (enter_show || ramp_tick),
        .terminal   (RAMP_LAST),
        .count      (ramp_count),
        .at_term    (ramp_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= STEP_W'(1);
        end else if (enter_show) begin
            step_q <= STEP_W'(1);
        end else if (ramp_tick && (step_q < STEP_MAX)) begin
            step_q <= step_q + 1'b1;
        end
    end

    assign bus.step_size = step_q;
`else
    assign bus.step_size = STEP_W'(DEFAULT_STEP);
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: one frame-vector table plus hand sequences for ramp and reset.
// Latency: checks one cycle after each next_frame and again later in the frame.
// Backpressure: not applicable.
module tb_pattern_sequencer;
    import pattern_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nf  = 1'b0;
    logic adv = 1'b0;
    logic hld = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pattern_sequencer_if #(.NUM_PATTERNS(3)) bus1 ();
    pattern_sequencer_if #(.NUM_PATTERNS(3)) bus2 ();

    assign bus1.next_frame = nf;
    assign bus1.advance    = adv;
    assign bus1.hold       = hld;
    assign bus2.next_frame = nf;
    assign bus2.advance    = adv;
    assign bus2.hold       = hld;

    pattern_sequencer #(
        .NUM_PATTERNS(3), .DWELL_FRAMES(4), .BLANK_FRAMES(2),
        .RAMP_FRAMES(2), .MAX_STEP(3), .DEFAULT_STEP(2)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pattern_sequencer #(
        .NUM_PATTERNS(3), .DWELL_FRAMES(8), .BLANK_FRAMES(2),
        .RAMP_FRAMES(2), .MAX_STEP(3), .DEFAULT_STEP(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        bit       adv_mid;
        bit       adv_nf;
        bit       hold;
        bit [2:0] en;
        bit [1:0] sel;
        bit       blank;
        bit [2:0] step;
    } vec_t;

    vec_t vecs[$];

    // Expected step_size: the ramp value when ramp is built, else the fixed default.
    function automatic int es(input int ramp_val);
`ifdef PATTERN_SEQ_RAMP_EN
        return ramp_val;
`else
        return 2 + (ramp_val - ramp_val);
`endif
    endfunction

    function automatic void add(input bit am, input bit an, input bit h,
                                input int en, input int sel, input bit bl, input int step);
        vec_t v;
        v.adv_mid = am;
        v.adv_nf  = an;
        v.hold    = h;
        v.en      = 3'(en);
        v.sel     = 2'(sel);
        v.blank   = bl;
        v.step    = 3'(es(step));
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycle(input logic f, input logic a);
        nf  = f;
        adv = a;
        @(posedge clk);
        #1;
        nf  = 1'b0;
        adv = 1'b0;
    endtask

    task automatic check1(input string tag, input int en, input int sel, input bit bl, input int step);
        check({tag, ".en"},    32'(bus1.pattern_enable), 32'(en));
        check({tag, ".sel"},   32'(bus1.pattern_sel),    32'(sel));
        check({tag, ".blank"}, 32'(bus1.blank),          32'(bl));
        check({tag, ".step"},  32'(bus1.step_size),      32'(step));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nf  = 1'b0;
        adv = 1'b0;
        hld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Free run and wrap (k1..k18)
        add(0,0,0, 1,0,0, 1); add(0,0,0, 1,0,0, 2); add(0,0,0, 1,0,0, 2);
        add(0,0,0, 0,0,1, 2); add(0,0,0, 0,0,1, 2);
        add(0,0,0, 2,1,0, 1); add(0,0,0, 2,1,0, 1); add(0,0,0, 2,1,0, 2); add(0,0,0, 2,1,0, 2);
        add(0,0,0, 0,1,1, 2); add(0,0,0, 0,1,1, 2);
        add(0,0,0, 4,2,0, 1); add(0,0,0, 4,2,0, 1); add(0,0,0, 4,2,0, 2); add(0,0,0, 4,2,0, 2);
        add(0,0,0, 0,2,1, 2); add(0,0,0, 0,2,1, 2);
        add(0,0,0, 1,0,0, 1);
        // Manual advance mid-frame, advance dropped in BLANK, full dwell afterwards (k19..k28)
        add(0,0,0, 1,0,0, 1); add(1,0,0, 0,0,1, 1); add(1,1,0, 0,0,1, 1);
        add(0,0,0, 2,1,0, 1); add(0,0,0, 2,1,0, 1); add(0,0,0, 2,1,0, 2); add(0,0,0, 2,1,0, 2);
        add(0,0,0, 0,1,1, 2); add(0,0,0, 0,1,1, 2); add(0,0,0, 4,2,0, 1);
        // Advance coincident with next_frame (k29..k31)
        add(0,1,0, 0,2,1, 1); add(0,0,0, 0,2,1, 1); add(0,0,0, 1,0,0, 1);
        // Hold for 10 frames, then advance while holding; hold ignored in BLANK (k32..k46)
        add(0,0,0, 1,0,0, 1); add(0,0,0, 1,0,0, 2);
        for (int i = 0; i < 10; i++) add(0,0,1, 1,0,0, 2);
        add(1,0,1, 0,0,1, 2); add(0,0,1, 0,0,1, 2); add(0,0,0, 2,1,0, 1);

        do_reset();
        check1("reset", 1, 0, 0, es(1));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i + 1);
            hld = vecs[i].hold;
            cycle(1'b0, vecs[i].adv_mid);
            cycle(1'b1, vecs[i].adv_nf);
            check1(tag, int'(vecs[i].en), int'(vecs[i].sel), vecs[i].blank, int'(vecs[i].step));
            cycle(1'b0, 1'b0);
            check({tag, ".en_late"},    32'(bus1.pattern_enable), 32'(vecs[i].en));
            check({tag, ".blank_late"}, 32'(bus1.blank),          32'(vecs[i].blank));
        end

        // Ramp on the long-dwell instance: 1,2,3,3 at SHOW frames 0,2,4,6, reset to 1 on next SHOW
        do_reset();
        check("ramp.f0", 32'(bus2.step_size), 32'(es(1)));
        for (int p = 1; p <= 10; p++) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
            if (p == 2) check("ramp.f2", 32'(bus2.step_size), 32'(es(2)));
            if (p == 4) check("ramp.f4", 32'(bus2.step_size), 32'(es(3)));
            if (p == 6) check("ramp.f6", 32'(bus2.step_size), 32'(es(3)));
            if (p == 7) check("ramp.f7_blank", 32'(bus2.blank), 32'd0);
            if (p == 8) begin
                check("ramp.f8_blank", 32'(bus2.blank), 32'd1);
                check("ramp.f8_step",  32'(bus2.step_size), 32'(es(3)));
            end
            if (p == 10) begin
                check("ramp.next_sel",  32'(bus2.pattern_sel), 32'd1);
                check("ramp.next_step", 32'(bus2.step_size),   32'(es(1)));
            end
        end

        // Async reset mid-frame in BLANK, with the blank counter part-way
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        check("rst.pre_blank", 32'(bus1.blank), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check1("rst.async", 1, 0, 0, es(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check1("rst.after", 1, 0, 0, es(1));
        for (int p = 1; p <= 4; p++) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
            check($sformatf("rst.dwell%0d", p), 32'(bus1.blank), (p == 4) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
